// File: rtl/apb_cmd_master.sv
// APB3 initiator: converts one valid/ready command into one APB transfer and
// returns read data / error status on a valid/ready response channel.
module apb_cmd_master #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  // command channel
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_WRITE,
  input  logic [ADR_W-1:0] CMD_ADDR,
  input  logic [DAT_W-1:0] CMD_WDATA,
  // response channel
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [DAT_W-1:0] RSP_RDATA,
  output logic             RSP_ERR,
  // APB3 bus
  output logic [ADR_W-1:0] PADDR,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [DAT_W-1:0] PWDATA,
  input  logic             PREADY,
  input  logic [DAT_W-1:0] PRDATA,
  input  logic             PSLVERR
);

  // Wide enough to hold TIMEOUT-1; abort fires before the counter could wrap.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             timeout_hit;

  logic [ADR_W-1:0] paddr_d;
  logic             psel_d;
  logic             penable_d;
  logic             pwrite_d;
  logic [DAT_W-1:0] pwdata_d;
  logic             rsp_valid_d;
  logic [DAT_W-1:0] rsp_rdata_d;
  logic             rsp_err_d;

  assign CMD_READY   = (state == IDLE) && !PRESET;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  always_comb begin
    // NOTE: every signal driven here is defaulted first so no latch is inferred.
    state_d     = state;
    wait_cnt_d  = wait_cnt;
    paddr_d     = PADDR;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    rsp_valid_d = RSP_VALID;
    rsp_rdata_d = RSP_RDATA;
    rsp_err_d   = RSP_ERR;

    unique case (state)
      IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          paddr_d  = CMD_ADDR;
          pwrite_d = CMD_WRITE;
          pwdata_d = CMD_WDATA;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
          state_d     = RESP;
        end else if (timeout_hit) begin
          // Slave never answered: release the bus and report an error.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else if (TIMEOUT != 0) begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end

      RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PADDR     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_cnt_d;
      PADDR     <= paddr_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      RSP_VALID <= rsp_valid_d;
      RSP_RDATA <= rsp_rdata_d;
      RSP_ERR   <= rsp_err_d;
    end
  end

endmodule
